// File: rtl/ntt_pkg.sv
// Shared types, default sizes and the reflection-permutation source-lane helper
// for the NTT lane commutator.
package ntt_pkg;

  localparam int NLANES_DEF = 8;
  localparam int W_DEF      = 32;
  localparam int BEATS_DEF  = 8;

  typedef logic [W_DEF-1:0] lane_t;

  // Source lane feeding output lane j at step s: lanes inside the reflection
  // window take in[s-j], lanes outside it pass straight through.
  function automatic int refl_src(input int s, input int j, input int nlanes);
    int d;
    d = s - j;
    if ((d >= 0) && (d <= nlanes - 1)) begin
      refl_src = d;
    end else begin
      refl_src = j;
    end
  endfunction

endpackage

// File: rtl/ntt_comm_seq.sv
// Frame sequencer: counts accepted beats and permutation steps, latches the
// frame direction at frame start and flags the last beat of a frame.
module ntt_comm_seq
  import ntt_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int BEATS  = BEATS_DEF,
  localparam int NSTEPS = 2 * NLANES - 1,
  localparam int SW     = $clog2(NSTEPS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          dir,
  input  logic          accept,
  output logic [SW-1:0] step_eff,
  output logic          frame_done
);

  localparam int BW = $clog2(BEATS) + 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(NSTEPS - 1);

  logic [BW-1:0] beat_cnt_r;
  logic [SW-1:0] step_cnt_r;
  logic          dir_q_r;
  logic          frame_start_s;
  logic          beat_last_s;
  logic          step_last_s;
  logic          dir_eff_s;

  // Decode counter positions and form the effective step; at frame start the
  // live dir input is used so beat 0 already follows the new direction.
  always_comb begin
    frame_start_s = (beat_cnt_r == {BW{1'b0}}) && (step_cnt_r == {SW{1'b0}});
    beat_last_s   = (beat_cnt_r == BEAT_LAST);
    step_last_s   = (step_cnt_r == STEP_LAST);
    if (frame_start_s) begin
      dir_eff_s = dir;
    end else begin
      dir_eff_s = dir_q_r;
    end
    if (dir_eff_s) begin
      step_eff = STEP_LAST - step_cnt_r;
    end else begin
      step_eff = step_cnt_r;
    end
    if (clear) begin
      frame_done = 1'b0;
    end else begin
      frame_done = accept & beat_last_s & step_last_s;
    end
  end

  // Beat/step counters and frame direction; advance only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= {BW{1'b0}};
      step_cnt_r <= {SW{1'b0}};
      dir_q_r    <= 1'b0;
    end else if (clear) begin
      beat_cnt_r <= {BW{1'b0}};
      step_cnt_r <= {SW{1'b0}};
    end else if (accept) begin
      if (frame_start_s) begin
        dir_q_r <= dir;
      end
      if (beat_last_s) begin
        beat_cnt_r <= {BW{1'b0}};
        if (step_last_s) begin
          step_cnt_r <= {SW{1'b0}};
        end else begin
          step_cnt_r <= step_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end
      end else begin
        beat_cnt_r <= beat_cnt_r + {{(BW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/ntt_lane_commutator.sv
// Lane commutator between NTT butterfly stages: time-varying reflection
// permutation across NLANES lanes with a single registered output stage and
// valid/ready flow control.
module ntt_lane_commutator
  import ntt_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int W      = W_DEF,
  parameter int BEATS  = BEATS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                dir,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NLANES*W-1:0] in_lanes,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NLANES*W-1:0] out_lanes,
  output logic                frame_done
);

  localparam int NSTEPS = 2 * NLANES - 1;
  localparam int SW     = $clog2(NSTEPS) + 1;
  localparam int LW     = $clog2(NLANES);

  logic          accept_s;
  logic [SW-1:0] step_eff_s;
  logic [W-1:0]  perm_s [NLANES];

  // Handshake: ready when the output slot is free or draining; clear blocks input.
  always_comb begin
    if (clear) begin
      in_ready = 1'b0;
    end else begin
      in_ready = !out_valid | out_ready;
    end
    accept_s = in_valid & in_ready;
  end

  ntt_comm_seq #(
    .NLANES (NLANES),
    .BEATS  (BEATS)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .dir        (dir),
    .accept     (accept_s),
    .step_eff   (step_eff_s),
    .frame_done (frame_done)
  );

  for (genvar j = 0; j < NLANES; j++) begin : g_lane
    logic [LW-1:0] src_s;

    // Select the source lane for output lane j at the current effective step.
    always_comb begin
      src_s     = LW'(refl_src(int'(step_eff_s), j, NLANES));
      perm_s[j] = in_lanes[src_s*W +: W];
    end
  end

  // Output register: loads on accept, empties when drained, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_lanes <= {(NLANES*W){1'b0}};
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      for (int k = 0; k < NLANES; k++) begin
        out_lanes[k*W +: W] <= perm_s[k];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ntt_lane_commutator.sv
// Self-checking bench: an 8-lane/8-beat instance and a 4-lane/1-beat instance,
// checked against a scoreboard of permuted beats computed from frame position.
module tb_ntt_lane_commutator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         a_clear, a_dir, a_iv, a_ir, a_ov, a_or, a_fd;
  logic [255:0] a_il, a_ol;
  logic         b_clear, b_dir, b_iv, b_ir, b_ov, b_or, b_fd;
  logic [63:0]  b_il, b_ol;

  int vecs = 0;
  int errs = 0;
  logic [255:0] sb [$];
  int   m_idx = 0;
  int   m_dir = 0;
  logic last_fd;
  int   fd_cnt;
  logic [255:0] lv, held;

  ntt_lane_commutator #(.NLANES(8), .W(32), .BEATS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .dir(a_dir),
    .in_valid(a_iv), .in_ready(a_ir), .in_lanes(a_il),
    .out_valid(a_ov), .out_ready(a_or), .out_lanes(a_ol), .frame_done(a_fd));

  ntt_lane_commutator #(.NLANES(4), .W(16), .BEATS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .dir(b_dir),
    .in_valid(b_iv), .in_ready(b_ir), .in_lanes(b_il),
    .out_valid(b_ov), .out_ready(b_or), .out_lanes(b_ol), .frame_done(b_fd));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reflection at step s: out[j] = in[s-j] when s-j is a valid lane, else in[j].
  function automatic logic [255:0] perm_ref(input logic [255:0] x, input int s,
                                            input int nl, input int w);
    logic [255:0] r;
    int src;
    r = '0;
    for (int j = 0; j < nl; j++) begin
      src = ((s - j >= 0) && (s - j < nl)) ? (s - j) : j;
      for (int b = 0; b < w; b++) r[j*w + b] = x[src*w + b];
    end
    return r;
  endfunction

  function automatic logic [255:0] ramp();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = 32'(j * 16);
    return r;
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle on the selected instance, entered and left at negedge.
  task automatic cycle(input bit sel, input bit iv, input bit ordy, input bit clr,
                       input bit d, input logic [255:0] lanes);
    int nl, w, beats, total, s;
    bit exp_ir, acc, fire;
    logic ir, ov, fd;
    logic [255:0] ol;
    nl = sel ? 4 : 8;
    w = sel ? 16 : 32;
    beats = sel ? 1 : 8;
    total = (2 * nl - 1) * beats;
    if (sel) begin
      b_iv = iv; b_or = ordy; b_clear = clr; b_dir = d; b_il = lanes[63:0];
      a_iv = 1'b0; a_or = 1'b1; a_clear = 1'b0;
    end else begin
      a_iv = iv; a_or = ordy; a_clear = clr; a_dir = d; a_il = lanes;
      b_iv = 1'b0; b_or = 1'b1; b_clear = 1'b0;
    end
    #1;
    ir = sel ? b_ir : a_ir;
    ov = sel ? b_ov : a_ov;
    fd = sel ? b_fd : a_fd;
    ol = sel ? {192'd0, b_ol} : a_ol;
    exp_ir = !clr && ((sb.size() == 0) || ordy);
    chk("in_ready", ir, exp_ir);
    chk("out_valid", ov, sb.size() != 0);
    if (sb.size() != 0) chk("out_lanes", ol, sb[0]);
    acc = iv && exp_ir;
    chk("frame_done", fd, acc && (m_idx == total - 1));
    last_fd = fd;
    fire = (sb.size() != 0) && ordy;
    @(posedge clk);
    if (clr) begin
      sb.delete();
      m_idx = 0;
    end else begin
      if (fire) void'(sb.pop_front());
      if (acc) begin
        if (m_idx == 0) m_dir = d;
        s = m_idx / beats;
        if (m_dir != 0) s = 2 * nl - 2 - s;
        sb.push_back(perm_ref(lanes, s, nl, w));
        m_idx = (m_idx + 1) % total;
      end
    end
    @(negedge clk);
  endtask

  task automatic rst_all();
    rst_n = 1'b0;
    a_iv = 1'b0; a_or = 1'b1; a_clear = 1'b0; a_dir = 1'b0; a_il = '0;
    b_iv = 1'b0; b_or = 1'b1; b_clear = 1'b0; b_dir = 1'b0; b_il = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    m_idx = 0;
    m_dir = 0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    a_iv = 1'b0; a_or = 1'b1; a_clear = 1'b0; a_dir = 1'b0; a_il = '0;
    b_iv = 1'b0; b_or = 1'b1; b_clear = 1'b0; b_dir = 1'b0; b_il = '0;
    #1;
    chk("rst_a_ov", a_ov, 1'b0);
    chk("rst_a_ol", a_ol, 256'd0);
    chk("rst_a_fd", a_fd, 1'b0);
    chk("rst_b_ov", b_ov, 1'b0);
    chk("rst_b_ol", b_ol, 256'd0);
    rst_all();

    // 1: ramp lanes, continuous flow, ascending
    fd_cnt = 0;
    for (int i = 0; i < 125; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ramp());
      if (last_fd) fd_cnt++;
      if (i == 56) begin
        chk("t1_s7_lane0", a_ol[31:0], 32'd112);
        chk("t1_s7_lane7", a_ol[255:224], 32'd0);
      end
      if (i == 64) begin
        chk("t1_s8_lane1", a_ol[63:32], 32'd112);
        chk("t1_s8_lane0", a_ol[31:0], 32'd0);
      end
      if (i == 119) chk("t1_fd_119", last_fd, 1'b1);
    end
    chk("t1_fd_count", fd_cnt, 1);

    // 2: descending frame, dir toggled mid-frame, next frame ascends
    rst_all();
    for (int i = 0; i < 150; i++) begin
      lv = rnd();
      cycle(1'b0, 1'b1, 1'b1, 1'b0, (i < 30) ? 1'b1 : 1'b0, lv);
      if (i == 0) chk("t2_beat0_identity", a_ol, lv);
      if (i == 56) chk("t2_s7_lane0", a_ol[31:0], lv[255:224]);
    end

    // 3: output stall of 5 cycles at beat 20
    rst_all();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd());
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rnd());
    held = a_ol;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rnd());
      chk("t3_hold", a_ol, held);
      chk("t3_in_ready_low", a_ir, 1'b0);
    end
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd());

    // 4: clear at beat 45 with a beat offered
    rst_all();
    for (int i = 0; i < 45; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd());
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, rnd());
    chk("t4_ov_after_clear", a_ov, 1'b0);
    lv = rnd();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lv);
    chk("t4_restart_identity", a_ol, lv);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rnd());

    // 5: asynchronous reset mid-frame, then restart
    rst_all();
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ramp());
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_ov", a_ov, 1'b0);
    chk("t5_async_ol", a_ol, 256'd0);
    chk("t5_async_fd", a_fd, 1'b0);
    rst_all();
    for (int i = 0; i < 65; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ramp());
      if (i == 56) chk("t5_s7_lane0", a_ol[31:0], 32'd112);
      if (i == 64) chk("t5_s8_lane1", a_ol[63:32], 32'd112);
    end

    // Randomized traffic on the 8-lane instance
    rst_all();
    for (int i = 0; i < 400; i++)
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), rnd());

    // 6: 4-lane, 1-beat instance
    rst_all();
    fd_cnt = 0;
    for (int i = 0; i < 23; i++) begin
      lv = rnd();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, lv);
      if (last_fd) fd_cnt++;
      if (i == 3) chk("t6_s3_lane0", b_ol[15:0], lv[63:48]);
      if (i == 5) begin
        chk("t6_s5_lane2", b_ol[47:32], lv[63:48]);
        chk("t6_s5_lane3", b_ol[63:48], lv[47:32]);
      end
    end
    chk("t6_fd_count", fd_cnt, 3);
    for (int i = 0; i < 200; i++)
      cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), rnd());

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
